dbg_dump: RTL and testbench

Debug dump engine that reads the CPU's debug inspection ports and streams their contents out as bytes. On a start pulse it walks the register-file port (checka/check), then the memory port (checkma/checkm). It emits a framed byte stream over a valid/ready interface, intended to feed a UART transmitter. It sits beside the top-level CPU+memory pair and acts as the initiator for the check/checkm ports that the top level exposes.

---
 rtl/dbg_pkg.sv | 28 ++
 rtl/dbg_shift.sv | 39 +++
 rtl/dbg_dump.sv | 129 ++++++++++++
 tb/tb_dbg_dump.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_pkg.sv
// dbg_pkg: shared state encodings, framing bytes and stream-length helper
// for the debug dump engine.
package dbg_pkg;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE  = 4'd0;
  localparam state_t ST_SYNC  = 4'd1;
  localparam state_t ST_RADDR = 4'd2;
  localparam state_t ST_RCAP  = 4'd3;
  localparam state_t ST_RSEND = 4'd4;
  localparam state_t ST_MADDR = 4'd5;
  localparam state_t ST_MCAP  = 4'd6;
  localparam state_t ST_MSEND = 4'd7;
  localparam state_t ST_TAIL  = 4'd8;
  localparam state_t ST_DONE  = 4'd9;

  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
  localparam logic [7:0] DEF_END_BYTE  = 8'h5A;

  // Bytes in one complete frame: header, register records, memory records, trailer.
  function automatic int unsigned stream_len(input int unsigned n,
                                             input int unsigned regs,
                                             input int unsigned mem_words);
    return 2 + regs * (n / 8) + mem_words * 4;
  endfunction

endpackage

// File: rtl/dbg_shift.sv
// dbg_shift: N-bit load / shift-left-by-8 register with a bytes-remaining
// counter. The top byte is always the next byte to send.
module dbg_shift
  import dbg_pkg::*;
#(
  parameter int N  = 64,
  parameter int CW = $clog2(N / 8 + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [N-1:0]  load_data,
  input  logic [CW-1:0] load_cnt,
  input  logic          shift,
  output logic [7:0]    byte_out,
  output logic          last
);

  logic [N-1:0]  sh;
  logic [CW-1:0] cnt;

  // Load a fresh record, or consume the top byte on each transfer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh  <= '0;
      cnt <= '0;
    end else if (load) begin
      sh  <= load_data;
      cnt <= load_cnt;
    end else if (shift) begin
      sh  <= {sh[N-9:0], 8'h00};
      if (cnt != '0) cnt <= cnt - 1'b1;
    end
  end

  assign byte_out = sh[N-1:N-8];
  assign last     = (cnt == CW'(1));

endmodule

// File: rtl/dbg_dump.sv
// dbg_dump: walks the register-file and memory inspection ports after a
// start pulse and streams a framed byte dump over valid/ready.
//
// state | meaning
// IDLE  | waiting for start
// SYNC  | presenting header byte
// RADDR | checka driven, register value settling
// RCAP  | register value captured into shift register
// RSEND | sending register record, MSB byte first
// MADDR | checkma driven, memory word settling
// MCAP  | memory word captured left-aligned
// MSEND | sending memory record, MSB byte first
// TAIL  | presenting trailer byte
// DONE  | one-cycle completion pulse
module dbg_dump
  import dbg_pkg::*;
#(
  parameter int         N         = 64,
  parameter int         REGS      = 32,
  parameter int         MEM_WORDS = 256,
  parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE,
  parameter logic [7:0] END_BYTE  = DEF_END_BYTE
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic [4:0]   checka,
  input  logic [N-1:0] check,
  output logic [7:0]   checkma,
  input  logic [31:0]  checkm,
  output logic [7:0]   out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int          CW    = $clog2(N / 8 + 1);
  localparam logic [CW-1:0] RCNT = CW'(N / 8);
  localparam logic [CW-1:0] MCNT = CW'(4);
  localparam logic [4:0]  RLAST = 5'(REGS - 1);
  localparam logic [7:0]  MLAST = 8'(MEM_WORDS - 1);

  state_t        state, state_nx;
  logic [4:0]    ridx;
  logic [7:0]    midx;
  logic          xfer;
  logic          sh_load;
  logic          sh_shift;
  logic [N-1:0]  sh_data;
  logic [N-1:0]  mword;
  logic [CW-1:0] sh_cnt;
  logic [7:0]    sh_byte;
  logic          sh_last;

  assign xfer = out_valid & out_ready;

  // Memory word is placed in the top 32 bits so its MSB leaves first.
  assign mword    = N'(checkm) << (N - 32);
  assign sh_load  = (state == ST_RCAP) || (state == ST_MCAP);
  assign sh_data  = (state == ST_MCAP) ? mword : check;
  assign sh_cnt   = (state == ST_MCAP) ? MCNT : RCNT;
  assign sh_shift = ((state == ST_RSEND) || (state == ST_MSEND)) && xfer;

  dbg_shift #(.N(N), .CW(CW)) u_shift (
    .clk       (clk),
    .reset     (reset),
    .load      (sh_load),
    .load_data (sh_data),
    .load_cnt  (sh_cnt),
    .shift     (sh_shift),
    .byte_out  (sh_byte),
    .last      (sh_last)
  );

  // Next-state decode.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (start) state_nx = ST_SYNC;
      ST_SYNC:  if (xfer) state_nx = ST_RADDR;
      ST_RADDR: state_nx = ST_RCAP;
      ST_RCAP:  state_nx = ST_RSEND;
      ST_RSEND: if (xfer && sh_last) state_nx = (ridx == RLAST) ? ST_MADDR : ST_RADDR;
      ST_MADDR: state_nx = ST_MCAP;
      ST_MCAP:  state_nx = ST_MSEND;
      ST_MSEND: if (xfer && sh_last) state_nx = (midx == MLAST) ? ST_TAIL : ST_MADDR;
      ST_TAIL:  if (xfer) state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // State register and record index counters; indices hold when unused.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      ridx  <= '0;
      midx  <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE && start) ridx <= '0;
      if (state == ST_RSEND && xfer && sh_last) begin
        if (ridx == RLAST) midx <= '0;
        else               ridx <= ridx + 1'b1;
      end
      if (state == ST_MSEND && xfer && sh_last && midx != MLAST) midx <= midx + 1'b1;
    end
  end

  // Byte presented to the transmitter, decoded from state.
  always_comb begin
    out_valid = 1'b0;
    out_data  = 8'h00;
    case (state)
      ST_SYNC:  begin out_valid = 1'b1; out_data = SYNC_BYTE; end
      ST_RSEND: begin out_valid = 1'b1; out_data = sh_byte;   end
      ST_MSEND: begin out_valid = 1'b1; out_data = sh_byte;   end
      ST_TAIL:  begin out_valid = 1'b1; out_data = END_BYTE;  end
      default:  ;
    endcase
  end

  assign busy    = (state != ST_IDLE) && (state != ST_DONE);
  assign done    = (state == ST_DONE);
  assign checka  = ridx;
  assign checkma = midx;

endmodule

// File: tb/tb_dbg_dump.sv
// tb_dbg_dump: directed bench for the debug dump engine, full-size and a
// reduced REGS=2 / MEM_WORDS=3 instance.
module tb_dbg_dump;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // main instance
  logic        start = 1'b0;
  logic        busy, done;
  logic [4:0]  checka;
  logic [63:0] check;
  logic [7:0]  checkma;
  logic [31:0] checkm;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        ready_level = 1'b1;
  logic        rand_ready = 1'b0;
  logic        rnd_bit = 1'b0;

  assign check     = {8{3'b000, checka}};
  assign checkm    = 32'hC0DE0000 | {24'h0, checkma};
  assign out_ready = rand_ready ? rnd_bit : ready_level;

  dbg_dump u_dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .checka(checka), .check(check), .checkma(checkma), .checkm(checkm),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  // reduced instance
  logic        start2 = 1'b0;
  logic        busy2, done2;
  logic [4:0]  checka2;
  logic [63:0] check2;
  logic [7:0]  checkma2;
  logic [31:0] checkm2;
  logic [7:0]  out_data2;
  logic        out_valid2;
  logic        out_ready2 = 1'b1;

  assign check2  = {8{3'b000, checka2}};
  assign checkm2 = 32'hC0DE0000 | {24'h0, checkma2};

  dbg_dump #(.REGS(2), .MEM_WORDS(3)) u_small (
    .clk(clk), .reset(reset), .start(start2), .busy(busy2), .done(done2),
    .checka(checka2), .check(check2), .checkma(checkma2), .checkm(checkm2),
    .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready2)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] q[$];
  logic [7:0] q2[$];
  int done_cnt = 0, busy_cnt = 0, viol = 0, done2_cnt = 0;
  int max_a2 = 0, max_ma2 = 0;
  bit hold = 0;
  logic [7:0] hold_data = 8'h00;

  always @(negedge clk) rnd_bit = 1'($urandom_range(0, 1));

  // monitor: samples just after the falling edge, ahead of the next rising edge
  always begin
    @(negedge clk);
    #1;
    if (!reset) begin
      hold = 0;
    end else begin
      if (out_valid && out_ready) q.push_back(out_data);
      if (done) done_cnt++;
      if (busy) busy_cnt++;
      if (hold && (!out_valid || out_data !== hold_data)) viol++;
      hold = out_valid && !out_ready;
      hold_data = out_data;
      if (out_valid2 && out_ready2) q2.push_back(out_data2);
      if (done2) done2_cnt++;
      if (int'(checka2) > max_a2) max_a2 = int'(checka2);
      if (int'(checkma2) > max_ma2) max_ma2 = int'(checkma2);
    end
  end

  // reference byte k of a frame: register i bytes all equal i, memory word j = C0DE00jj
  function automatic logic [7:0] exp_byte(input int k, input int regs, input int mem);
    int r;
    if (k == 0) return 8'hA5;
    r = k - 1;
    if (r < regs * 8) return 8'(r / 8);
    r = r - regs * 8;
    if (r < mem * 4) begin
      case (r % 4)
        0: return 8'hC0;
        1: return 8'hDE;
        2: return 8'h00;
        default: return 8'(r / 4);
      endcase
    end
    return 8'h5A;
  endfunction

  function automatic int first_bad(input logic [7:0] s[$], input int regs, input int mem);
    for (int i = 0; i < s.size(); i++)
      if (s[i] !== exp_byte(i, regs, mem)) return i;
    return -1;
  endfunction

  task automatic clear_mon();
    q.delete(); q2.delete();
    done_cnt = 0; busy_cnt = 0; viol = 0; done2_cnt = 0;
    max_a2 = 0; max_ma2 = 0;
  endtask

  task automatic kick();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // wait for done; optionally re-pulse start or assert reset once enough bytes have moved
  task automatic wait_main(input int budget, input int restart_at, input int abort_at,
                           output bit aborted);
    bit restarted = 0;
    int n = 0;
    aborted = 0;
    while (1) begin
      @(negedge clk); start = 1'b0; #2;
      if (done_cnt > 0) break;
      if (abort_at >= 0 && q.size() >= abort_at) begin
        reset = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin
          miscompares++; $display("FAIL abort_valid got=%b want=0", out_valid);
        end
        vectors++;
        if (busy !== 1'b0) begin
          miscompares++; $display("FAIL abort_busy got=%b want=0", busy);
        end
        aborted = 1;
        break;
      end
      if (restart_at >= 0 && !restarted && q.size() >= restart_at) begin
        start = 1'b1;
        restarted = 1;
      end
      n++;
      if (n >= budget) begin
        vectors++; miscompares++;
        $display("FAIL wait_done timeout after %0d cycles, bytes=%0d", n, q.size());
        break;
      end
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy, done, out_valid} !== 3'b000) begin
      miscompares++; $display("FAIL reset_flags got=%b want=000", {busy, done, out_valid});
    end
    vectors++;
    if (out_data !== 8'h00) begin
      miscompares++; $display("FAIL reset_data got=%h want=00", out_data);
    end
    vectors++;
    if (checka !== 5'd0 || checkma !== 8'd0) begin
      miscompares++; $display("FAIL reset_index got=%0d/%0d want=0/0", checka, checkma);
    end
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    bit ab;
    int b;
    clear_mon();
    ready_level = 1'b1;
    kick();
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
      miscompares++; $display("FAIL start_latency got=%b/%h want=1/a5", out_valid, out_data);
    end
    wait_main(5000, -1, -1, ab);
    vectors++;
    if (q.size() !== 1282) begin
      miscompares++; $display("FAIL basic_len got=%0d want=1282", q.size());
    end
    b = first_bad(q, 32, 256);
    vectors++;
    if (b !== -1) begin
      miscompares++;
      $display("FAIL basic_bytes at=%0d got=%h want=%h", b, q[b], exp_byte(b, 32, 256));
    end
    vectors++;
    if (done_cnt !== 1) begin
      miscompares++; $display("FAIL basic_done got=%0d want=1", done_cnt);
    end
    vectors++;
    if (busy_cnt !== 1858) begin
      miscompares++; $display("FAIL basic_busy_cycles got=%0d want=1858", busy_cnt);
    end
  endtask

  task automatic test_random_ready();
    bit ab;
    int b;
    clear_mon();
    rand_ready = 1'b1;
    kick();
    wait_main(20000, -1, -1, ab);
    rand_ready = 1'b0;
    vectors++;
    if (q.size() !== 1282) begin
      miscompares++; $display("FAIL rand_len got=%0d want=1282", q.size());
    end
    b = first_bad(q, 32, 256);
    vectors++;
    if (b !== -1) begin
      miscompares++;
      $display("FAIL rand_bytes at=%0d got=%h want=%h", b, q[b], exp_byte(b, 32, 256));
    end
    vectors++;
    if (viol !== 0) begin
      miscompares++; $display("FAIL rand_stable got=%0d violations want=0", viol);
    end
  endtask

  task automatic test_start_ignored();
    bit ab;
    int b;
    clear_mon();
    ready_level = 1'b1;
    kick();
    wait_main(5000, 100, -1, ab);
    vectors++;
    if (q.size() !== 1282) begin
      miscompares++; $display("FAIL restart_len got=%0d want=1282", q.size());
    end
    b = first_bad(q, 32, 256);
    vectors++;
    if (b !== -1) begin
      miscompares++;
      $display("FAIL restart_bytes at=%0d got=%h want=%h", b, q[b], exp_byte(b, 32, 256));
    end
    vectors++;
    if (done_cnt !== 1) begin
      miscompares++; $display("FAIL restart_done got=%0d want=1", done_cnt);
    end
  endtask

  task automatic test_abort();
    bit ab;
    int b;
    clear_mon();
    ready_level = 1'b1;
    kick();
    wait_main(5000, -1, 500, ab);
    vectors++;
    if (ab !== 1'b1) begin
      miscompares++; $display("FAIL abort_reached got=%b want=1", ab);
    end
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    clear_mon();
    kick();
    wait_main(5000, -1, -1, ab);
    b = first_bad(q, 32, 256);
    vectors++;
    if (q.size() !== 1282 || b !== -1) begin
      miscompares++; $display("FAIL abort_restream len=%0d first_bad=%0d want=1282/-1", q.size(), b);
    end
  endtask

  task automatic test_stall();
    bit ab;
    int bad = 0;
    int b;
    clear_mon();
    ready_level = 1'b0;
    kick();
    repeat (1000) begin
      if (out_valid !== 1'b1 || out_data !== 8'hA5) bad++;
      @(negedge clk);
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++; $display("FAIL stall_hold got=%0d bad cycles want=0", bad);
    end
    ready_level = 1'b1;
    wait_main(5000, -1, -1, ab);
    b = first_bad(q, 32, 256);
    vectors++;
    if (q.size() !== 1282 || b !== -1) begin
      miscompares++; $display("FAIL stall_resume len=%0d first_bad=%0d want=1282/-1", q.size(), b);
    end
  endtask

  task automatic test_small();
    int n = 0;
    int b;
    clear_mon();
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    while (done2_cnt == 0 && n < 500) begin
      @(negedge clk); #2;
      n++;
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (q2.size() !== 30) begin
      miscompares++; $display("FAIL small_len got=%0d want=30", q2.size());
    end
    b = first_bad(q2, 2, 3);
    vectors++;
    if (b !== -1) begin
      miscompares++;
      $display("FAIL small_bytes at=%0d got=%h want=%h", b, q2[b], exp_byte(b, 2, 3));
    end
    vectors++;
    if (max_a2 > 1 || max_ma2 > 2) begin
      miscompares++; $display("FAIL small_index_max got=%0d/%0d want<=1/2", max_a2, max_ma2);
    end
    vectors++;
    if (done2_cnt !== 1) begin
      miscompares++; $display("FAIL small_done got=%0d want=1", done2_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random_ready();
    test_start_ignored();
    test_abort();
    test_stall();
    test_small();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
